mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//   Control FSM for the MAR/MDR/IR memory path. Sequences instruction fetch (MAR<-PC, read, MDR<-mem, IR<-MDR)
//   and execute-stage data accesses (load/store) over a single MFA/MOC memory handshake.
//   Drives the load enables of IR/MAR/MDR and the MAR/MDR source selects; sits between the datapath and memory.
//   Detects a memory that never answers, via a bounded wait with a sticky timeout error.
// PARAMETERS
//   TIMEOUT  15  max cycles MFA may stay high without MOC before error (>=2)
//   CNT_W    4   wait-counter width; must satisfy 2**CNT_W >= TIMEOUT
// PORTS
//   CLK      in   1  clock, rising edge; single clock domain
//   RST      in   1  reset, synchronous, active-high
//   Start    in   1  begin first fetch; sampled in IDLE only
//   Next     in   1  request next instruction fetch; sampled in READY only
//   MemReq   in   1  execute-stage data access request; sampled in READY only, held until MemDone
//   MemRW    in   1  data access direction, 1=store, 0=load; sampled with MemReq
//   MOC      in   1  memory operation complete; used only in FMEM/DMEM
//   MFA      out  1  memory function active (request to memory)
//   RW       out  1  memory direction, 1=write, 0=read; 0 whenever MFA=0
//   MARLd    out  1  MAR load enable
//   MARSel   out  1  MAR source, 0=PC, 1=ALU address
//   MDRLd    out  1  MDR load enable
//   MDRSel   out  1  MDR source, 0=memory bus, 1=datapath store data
//   IRLd     out  1  IR load enable
//   PCInc    out  1  PC increment pulse
//   IRValid  out  1  IR holds a valid instruction (high in READY and the DMAR..DDONE states)
//   MemDone  out  1  one-cycle pulse, data access finished
//   Busy     out  1  high in every state except IDLE, READY, ERR
//   Timeout  out  1  sticky error flag; cleared only by RST
// BEHAVIOUR
//   Reset: state=IDLE, wait counter=0, stored direction wr_q=0, all outputs 0.
//   RST wins over all other inputs in any state, including mid-handshake; MFA drops at that edge.
//   States and transitions (one per clock edge):
//   - IDLE: Start=1 -> FMAR; all other inputs ignored.
//   - FMAR: MARLd=1, MARSel=0 -> FMEM.
//   - FMEM: MFA=1, RW=0. On MOC=1: MDRLd=1, MDRSel=0, PCInc=1 in the same cycle -> FIR.
//   - FIR: IRLd=1 -> READY.
//   - READY: IRValid=1. MemReq=1 -> DMAR and wr_q<=MemRW; else Next=1 -> FMAR. MemReq has priority over Next.
//   - DMAR: MARLd=1, MARSel=1 -> DMDR if wr_q=1, else DMEM.
//   - DMDR: MDRLd=1, MDRSel=1 -> DMEM.
//   - DMEM: MFA=1, RW=wr_q. On MOC=1 -> DDONE; for a load (wr_q=0), MDRLd=1 with MDRSel=0 in the MOC cycle.
//   - DDONE: MemDone=1 -> READY.
//   - ERR: Timeout=1 and all other outputs 0; stays in ERR until RST.
//   Outputs decode from state, except MDRLd and PCInc in FMEM/DMEM, which are qualified by MOC.
//   Wait counter:
//   - clears on entry to FMEM/DMEM and increments each cycle the state stays there with MOC=0.
//   - When count==TIMEOUT-1 and MOC=0 -> ERR, so MFA is high for exactly TIMEOUT cycles.
//   - If MOC=1 in the limit cycle, MOC wins and there is no error.
//   MOC already high on the first FMEM/DMEM cycle completes with 1-cycle latency.
//   Fetch latency, Start to IRLd: 3 + (MFA cycles) clock cycles.
//   MemRW is not resampled after READY; changes to it during an access are ignored.
// TESTING
//   1 RST; Start=1 for 1 cycle; MOC high on 3rd MFA cycle -> MARLd(MARSel=0) 1 cyc; MFA 3 cyc; MDRLd+PCInc on MOC cycle; IRLd; IRValid=1.
//   2 READY, MemReq=1, MemRW=0, MOC=1 immediately -> MARLd(MARSel=1); MFA 1 cyc with RW=0 and MDRLd(MDRSel=0); MemDone pulse; back to READY.
//   3 READY, MemReq=1, MemRW=1 -> MARLd; MDRLd(MDRSel=1) before MFA; RW=1 during MFA; no MDRLd in DMEM; MemDone.
//   4 TIMEOUT=15, MOC never -> MFA high exactly 15 cycles, then Timeout=1, MFA=0, held 20+ cycles; RST clears Timeout.
//   5 MOC on 15th MFA cycle -> access completes normally, Timeout stays 0.
//   6a RST during FMEM -> next edge all outputs 0, state IDLE.
//   6b MemReq=1 and Next=1 together in READY -> data access runs first, then fetch on Next.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//   Handshake/control bundle between the memory-path controller, the
//   datapath and the memory.
//   Requests in:  Start, Next, MemReq, MemRW, MOC
//   Controls out: MFA, RW, MARLd, MARSel, MDRLd, MDRSel, IRLd, PCInc
//   Status out:   IRValid, MemDone, Busy, Timeout
//   slave modport  : the controller (mem_access_ctrl)
//   master modport : the datapath/memory side driving the requests
interface mem_access_ctrl_if;
  logic Start;
  logic Next;
  logic MemReq;
  logic MemRW;
  logic MOC;
  logic MFA;
  logic RW;
  logic MARLd;
  logic MARSel;
  logic MDRLd;
  logic MDRSel;
  logic IRLd;
  logic PCInc;
  logic IRValid;
  logic MemDone;
  logic Busy;
  logic Timeout;

  modport slave (
    input  Start, Next, MemReq, MemRW, MOC,
    output MFA, RW, MARLd, MARSel, MDRLd, MDRSel, IRLd, PCInc,
           IRValid, MemDone, Busy, Timeout
  );

  modport master (
    output Start, Next, MemReq, MemRW, MOC,
    input  MFA, RW, MARLd, MARSel, MDRLd, MDRSel, IRLd, PCInc,
           IRValid, MemDone, Busy, Timeout
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Control FSM for the MAR/MDR/IR memory path. Sequences instruction
//   fetches and execute-stage loads/stores over one MFA/MOC handshake and
//   raises a sticky Timeout if memory does not answer within TIMEOUT cycles.
//   CLK : rising-edge clock
//   RST : synchronous active-high reset
//   bus : mem_access_ctrl_if.slave (requests in, load enables/selects/status out)
//   TIMEOUT : max MFA cycles without MOC (>=2); CNT_W : counter width, 2**CNT_W >= TIMEOUT
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  mem_access_ctrl_if.slave   bus
);

  typedef enum logic [3:0] {
    IDLE,
    FMAR,
    FMEM,
    FIR,
    READY,
    DMAR,
    DMDR,
    DMEM,
    DDONE,
    ERR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    // Counter is held at zero outside FMEM/DMEM, so it is already clear on entry.
    cnt_d       = '0;
    wr_d        = wr_q;
    bus.MFA     = 1'b0;
    bus.RW      = 1'b0;
    bus.MARLd   = 1'b0;
    bus.MARSel  = 1'b0;
    bus.MDRLd   = 1'b0;
    bus.MDRSel  = 1'b0;
    bus.IRLd    = 1'b0;
    bus.PCInc   = 1'b0;
    bus.IRValid = 1'b0;
    bus.MemDone = 1'b0;
    bus.Busy    = 1'b1;
    bus.Timeout = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.Busy = 1'b0;
        if (bus.Start) state_d = FMAR;
      end
      FMAR: begin
        bus.MARLd = 1'b1;
        state_d   = FMEM;
      end
      FMEM: begin
        bus.MFA = 1'b1;
        if (bus.MOC) begin
          bus.MDRLd = 1'b1;
          bus.PCInc = 1'b1;
          state_d   = FIR;
        end else if (cnt_q == CNT_LIM) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIR: begin
        bus.IRLd = 1'b1;
        state_d  = READY;
      end
      READY: begin
        bus.IRValid = 1'b1;
        bus.Busy    = 1'b0;
        if (bus.MemReq) begin
          wr_d    = bus.MemRW;
          state_d = DMAR;
        end else if (bus.Next) begin
          state_d = FMAR;
        end
      end
      DMAR: begin
        bus.IRValid = 1'b1;
        bus.MARLd   = 1'b1;
        bus.MARSel  = 1'b1;
        state_d     = wr_q ? DMDR : DMEM;
      end
      DMDR: begin
        bus.IRValid = 1'b1;
        bus.MDRLd   = 1'b1;
        bus.MDRSel  = 1'b1;
        state_d     = DMEM;
      end
      DMEM: begin
        bus.IRValid = 1'b1;
        bus.MFA     = 1'b1;
        bus.RW      = wr_q;
        if (bus.MOC) begin
          bus.MDRLd = ~wr_q;
          state_d   = DDONE;
        end else if (cnt_q == CNT_LIM) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DDONE: begin
        bus.IRValid = 1'b1;
        bus.MemDone = 1'b1;
        state_d     = READY;
      end
      ERR: begin
        bus.Busy    = 1'b0;
        bus.Timeout = 1'b1;
      end
      default: begin
        bus.Busy = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Directed, table-driven bench for mem_access_ctrl. Each record is one
//   clock cycle: inputs driven after the falling edge, outputs compared
//   1 time unit later (before the next rising edge).
//   Output vector: {MFA,RW,MARLd,MARSel,MDRLd,MDRSel,IRLd,PCInc,IRValid,MemDone,Busy,Timeout}
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        start;
    logic        next;
    logic        req;
    logic        rw;
    logic        moc;
    logic        chk;
    logic [11:0] exp;
  } vec_t;

  localparam logic [11:0] E_IDLE  = 12'b0000_0000_0000;
  localparam logic [11:0] E_FMAR  = 12'b0010_0000_0010;
  localparam logic [11:0] E_FMW   = 12'b1000_0000_0010;
  localparam logic [11:0] E_FMM   = 12'b1000_1001_0010;
  localparam logic [11:0] E_FIR   = 12'b0000_0010_0010;
  localparam logic [11:0] E_READY = 12'b0000_0000_1000;
  localparam logic [11:0] E_DMAR  = 12'b0011_0000_1010;
  localparam logic [11:0] E_DMDR  = 12'b0000_1100_1010;
  localparam logic [11:0] E_DLW   = 12'b1000_0000_1010;
  localparam logic [11:0] E_DLM   = 12'b1000_1000_1010;
  localparam logic [11:0] E_DST   = 12'b1100_0000_1010;
  localparam logic [11:0] E_DDONE = 12'b0000_0000_1110;
  localparam logic [11:0] E_ERR   = 12'b0000_0000_0001;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  vec_t        vecs[$];

  function automatic vec_t mk(logic r, logic s, logic n, logic q, logic w,
                              logic m, logic c, logic [11:0] e);
    vec_t v;
    v.rst = r; v.start = s; v.next = n; v.req = q; v.rw = w; v.moc = m;
    v.chk = c; v.exp = e;
    return v;
  endfunction

  function automatic logic [11:0] outs();
    return {bus.MFA, bus.RW, bus.MARLd, bus.MARSel, bus.MDRLd, bus.MDRSel,
            bus.IRLd, bus.PCInc, bus.IRValid, bus.MemDone, bus.Busy, bus.Timeout};
  endfunction

  task automatic step(input vec_t v, input string tag, input int idx);
    @(negedge clk);
    rst        = v.rst;
    bus.Start  = v.start;
    bus.Next   = v.next;
    bus.MemReq = v.req;
    bus.MemRW  = v.rw;
    bus.MOC    = v.moc;
    #1;
    if (v.chk) begin
      n_checks++;
      if (outs() !== v.exp) begin
        n_fail++;
        $display("FAIL %s[%0d] outputs got %b want %b", tag, idx, outs(), v.exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.Start = 1'b0; bus.Next = 1'b0; bus.MemReq = 1'b0;
    bus.MemRW = 1'b0; bus.MOC = 1'b0;

    //                 rst st nx rq rw moc chk exp
    // fetch with MOC on the 3rd MFA cycle
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, E_IDLE));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, E_IDLE));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, E_FMAR));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, E_FMW));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, E_FMW));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, E_FMM));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, E_FIR));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, E_READY));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, E_READY));
    // load, MOC immediately
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, E_READY));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, E_DMAR));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, E_DLM));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, E_DDONE));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, E_READY));
    // store; MemRW dropped mid-access must be ignored
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, E_READY));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, E_DMAR));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, E_DMDR));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, E_DST));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, E_DST));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, E_DDONE));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, E_READY));
    // MemReq and Next together: data access first, then fetch
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, E_READY));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, E_DMAR));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, E_DLW));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1, E_DLM));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, E_DDONE));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, E_READY));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, E_FMAR));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, E_FMM));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, E_FIR));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, E_READY));
    // reset during FMEM
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, E_READY));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, E_FMAR));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, E_FMW));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, E_IDLE));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, E_IDLE));

    foreach (vecs[i]) step(vecs[i], "vec", i);

    // MOC arrives on the 15th (limit) MFA cycle: completes, no error
    step(mk(0, 1, 0, 0, 0, 0, 1, E_IDLE), "lim", 0);
    step(mk(0, 0, 0, 0, 0, 0, 1, E_FMAR), "lim", 1);
    for (int i = 0; i < 14; i++) step(mk(0, 0, 0, 0, 0, 0, 1, E_FMW), "lim_wait", i);
    step(mk(0, 0, 0, 0, 0, 1, 1, E_FMM), "lim", 2);
    step(mk(0, 0, 0, 0, 0, 0, 1, E_FIR), "lim", 3);
    step(mk(0, 0, 0, 0, 0, 0, 1, E_READY), "lim", 4);

    // memory never answers: exactly 15 MFA cycles, then sticky Timeout
    step(mk(0, 0, 1, 0, 0, 0, 1, E_READY), "tmo", 0);
    step(mk(0, 0, 0, 0, 0, 0, 1, E_FMAR), "tmo", 1);
    for (int i = 0; i < 15; i++) step(mk(0, 0, 0, 0, 0, 0, 1, E_FMW), "tmo_wait", i);
    for (int i = 0; i < 22; i++)
      step(mk(0, i[0], i[1], i[2], 1, i[0], 1, E_ERR), "tmo_err", i);
    step(mk(1, 0, 0, 0, 0, 0, 1, E_ERR), "tmo", 2);
    step(mk(0, 0, 0, 0, 0, 0, 1, E_IDLE), "tmo", 3);
    step(mk(0, 1, 0, 0, 0, 0, 1, E_IDLE), "tmo", 4);
    step(mk(0, 0, 0, 0, 0, 0, 1, E_FMAR), "tmo", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
